// File: rtl/lzc_seq.sv
// lzc_seq: multi-cycle leading-zero counter scanning CHUNK_SZ-bit slices MSB-first through one shared LZC.
// Define LZC_SEQ_EARLY_EXIT_EN to stop scanning at the first nonzero slice (data-dependent latency).
module leading_zero_cnt #(
    parameter int W = 32
) (
    input  logic [W-1:0]       i_data,
    output logic [$clog2(W):0] o_cnt
);
    localparam int CW = $clog2(W) + 1;
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (i_data[i]) o_cnt = CW'(W - 1 - i);
    end
endmodule

module lzc_seq #(
    parameter int WI_SZ    = 128,
    parameter int CHUNK_SZ = 32,
    parameter int WO_SZ    = $clog2(WI_SZ) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WI_SZ-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WO_SZ-1:0] out_cnt,
    output logic             out_zero,
    output logic             busy
);
    localparam int NCHUNK = WI_SZ / CHUNK_SZ;
    localparam int IW     = $clog2(NCHUNK);
    localparam int CW     = $clog2(CHUNK_SZ) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           r_state;
    logic [WI_SZ-1:0] r_op;
    logic [IW-1:0]    r_idx;
    logic [WO_SZ-1:0] r_acc;
    logic             r_found;
    logic             r_out_valid;
    logic [WO_SZ-1:0] r_out_cnt;
    logic             r_out_zero;

    logic [CW-1:0]    w_c;
    logic [WO_SZ-1:0] w_acc_nx;
    logic             w_found_nx;
    logic             w_last;
    logic             w_exit;

    // The operand shifts left each SCAN cycle, so the current chunk is always the top slice.
    leading_zero_cnt #(.W(CHUNK_SZ)) u_lzc (
        .i_data(r_op[WI_SZ-1 -: CHUNK_SZ]),
        .o_cnt (w_c)
    );

    assign w_acc_nx   = r_found ? r_acc : r_acc + WO_SZ'(w_c);
    assign w_found_nx = r_found | (w_c != CW'(CHUNK_SZ));
    assign w_last     = r_idx == IW'(NCHUNK - 1);
`ifdef LZC_SEQ_EARLY_EXIT_EN
    assign w_exit     = w_last | w_found_nx;
`else
    assign w_exit     = w_last;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_found     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_cnt   <= '0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op    <= in_data;
                    r_idx   <= '0;
                    r_acc   <= '0;
                    r_found <= 1'b0;
                    r_state <= SCAN;
                end
                SCAN: begin
                    r_acc   <= w_acc_nx;
                    r_found <= w_found_nx;
                    r_op    <= r_op << CHUNK_SZ;
                    r_idx   <= r_idx + 1'b1;
                    if (w_exit) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out_cnt   <= w_acc_nx;
                        r_out_zero  <= w_acc_nx == WO_SZ'(WI_SZ);
                    end
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n & (r_state == IDLE);
    assign busy      = r_state != IDLE;
    assign out_valid = r_out_valid;
    assign out_cnt   = r_out_cnt;
    assign out_zero  = r_out_zero;
endmodule

// File: tb/tb_lzc_seq.sv
// tb_lzc_seq: directed table, corner-case sequences and randomized operands against a bit-scan reference model.
module tb_lzc_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_cnt;
    logic         out_zero;
    logic         busy;

    int n_vec = 0;
    int n_bad = 0;

`ifdef LZC_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    lzc_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cnt(out_cnt), .out_zero(out_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        int           cnt;
        bit           z;
        int           lat_ee;
        int           lat_full;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_lz(input logic [127:0] d);
        for (int i = 127; i >= 0; i--)
            if (d[i]) return 127 - i;
        return 128;
    endfunction

    function automatic int ref_lat(input int cnt);
        if (!EE || cnt == 128) return 5;
        return cnt / 32 + 2;
    endfunction

    task automatic run_op(input logic [127:0] d, input int cnt, input bit z, input int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        n = 1;
        chk("busy_scan", busy, 1);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat);
        chk("out_cnt", out_cnt, cnt);
        chk("out_zero", out_zero, z);
        chk("in_ready_done", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    vec_t         tbl[7];
    logic [127:0] r;
    logic [7:0]   res[$];
    logic [7:0]   held_cnt;
    logic         held_zero;
    bit           seen;
    int           acc_a, acc_b, hs_a, c;

    initial begin
        tbl[0] = '{128'h0000_0000_0000_8000_0000_0000_0000_0000, 48, 1'b0, 3, 5};
        tbl[1] = '{128'h0, 128, 1'b1, 5, 5};
        tbl[2] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 0, 1'b0, 2, 5};
        tbl[3] = '{128'h1, 127, 1'b0, 5, 5};
        tbl[4] = '{128'h0000_0010_0000_0000_0000_0000_0000_0000, 27, 1'b0, 2, 5};
        tbl[5] = '{128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000, 32, 1'b0, 3, 5};
        tbl[6] = '{128'h0000_0000_0000_0000_0000_0000_8000_0000, 96, 1'b0, 5, 5};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_zero", out_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        foreach (tbl[i])
            run_op(tbl[i].d, tbl[i].cnt, tbl[i].z, EE ? tbl[i].lat_ee : tbl[i].lat_full);

        // backpressure: result must hold for 10 stalled cycles
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 128'h0000_0000_0000_8000_0000_0000_0000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("bp_valid", out_valid, 1);
        held_cnt  = out_cnt;
        held_zero = out_zero;
        chk("bp_cnt", held_cnt, 48);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_cnt", out_cnt, held_cnt);
            chk("bp_hold_zero", out_zero, held_zero);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);

        // reset in cycle 2 of a scan drops the operand
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 128'h1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", out_cnt, 0);
        chk("mid_rst_zero", out_zero, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("mid_rst_no_result", seen, 0);
        run_op(128'h1, 127, 1'b0, 5);

        // back-to-back with in_valid held high
        @(negedge clk);
        acc_a = -1; acc_b = -1; hs_a = -1;
        res.delete();
        in_valid  = 1'b1;
        in_data   = 128'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && res.size() < 2; i++) begin
            if (acc_a >= 0) in_data = 128'h1 << 100;
            if (acc_b >= 0) in_valid = 1'b0;
            if (in_valid && in_ready) begin
                if (acc_a < 0) acc_a = i;
                else acc_b = i;
            end
            if (out_valid && out_ready) begin
                res.push_back(out_cnt);
                if (hs_a < 0) hs_a = i;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", res.size(), 2);
        chk("b2b_res_a", res.size() > 0 ? res[0] : 8'hff, 128);
        chk("b2b_res_b", res.size() > 1 ? res[1] : 8'hff, 27);
        chk("b2b_accept_b", acc_b, hs_a + 1);

        for (int i = 0; i < 200; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 128);
            c = ref_lz(r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(r, c, c == 128, ref_lat(c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/lzc_seq.md
# lzc_seq

Sequential leading-zero counter for wide words. It scans a `WI_SZ`-bit operand MSB-first in `CHUNK_SZ`-bit slices through one shared `leading_zero_cnt` instance and accumulates the per-slice counts into a full-width result. It sits between a producer (normalizer/FP-align front end) and a consumer, with valid/ready handshakes on both sides. It trades latency for area compared with a full-width combinational LZC.

## Interface
Parameters:
- `WI_SZ`, 128, operand width. Must be a multiple of `CHUNK_SZ`.
- `CHUNK_SZ`, 32, slice width fed to the shared LZC. Power of 2, ≥2; `WI_SZ/CHUNK_SZ` ≥2.
- `WO_SZ`, `$clog2(WI_SZ)+1`, result width. Holds values 0..`WI_SZ`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  `WI_SZ`  operand.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_cnt`  out  `WO_SZ`  leading-zero count of the accepted operand.
- `out_zero`  out  1  operand was all zeros (`out_cnt == WI_SZ`).
- `busy`  out  1  FSM not in IDLE.

## Operation
- `NCHUNK = WI_SZ/CHUNK_SZ`. Chunk k covers `in_data[WI_SZ-1-k*CHUNK_SZ -: CHUNK_SZ]`, so chunk 0 is the MSB slice.
- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid && in_ready`: capture `in_data` into the operand register, set chunk index=0, acc=0, found=0, then go to SCAN.
- **SCAN**
  - The current chunk drives the shared LZC, giving count c (`$clog2(CHUNK_SZ)+1` bits, zero-extended to `WO_SZ`).
  - If !found: acc += c. If c < `CHUNK_SZ`, set found=1.
  - If found: acc holds.
  - Go to DONE when the index equals `NCHUNK-1`, or when early exit fires (see Configuration). Otherwise increment the index.
- **DONE**
  - `out_valid=1`, `out_cnt=acc`, `out_zero=(acc==WI_SZ)`.
  - Outputs stay stable until `out_valid && out_ready`, then go to IDLE.
- One transaction in flight at a time. `in_ready=0` in SCAN and DONE, including the DONE handshake cycle.
- `out_valid` must not depend combinationally on `out_ready`.
- The acc sum cannot overflow, because `WO_SZ` holds `WI_SZ`.
- Reset (`rst_n` low at an edge), including mid-SCAN or mid-DONE:
  - State goes to IDLE.
  - `out_valid=0`, `out_cnt=0`, `out_zero=0`, `busy=0`.
  - Operand/acc/index/found cleared; the in-flight transaction is dropped and never reported.
  - `in_ready` is forced 0 while `rst_n` is low and is 1 from the first cycle after release.

## Timing
- Cycle 0 is the cycle in which `in_valid && in_ready` is sampled. Chunk k is evaluated in cycle k+1.
- With early exit, first nonzero chunk k: `out_valid` rises in cycle k+2.
- Without early exit, or for an all-zero operand: `out_valid` rises in cycle `NCHUNK+1`.
- The result handshake in cycle t puts the FSM in IDLE at cycle t+1, with `in_ready=1` that cycle. Minimum initiation interval is latency+1.
- `out_cnt`/`out_zero` are registered outputs. No combinational path from `in_data` to any output.

## Configuration
- Macro: `LZC_SEQ_EARLY_EXIT_EN`.
- **Defined:** SCAN goes to DONE in the cycle the first nonzero chunk is seen. Latency is data-dependent, from 2 to `NCHUNK+1`.
- **Undefined:** SCAN always visits all `NCHUNK` chunks, with acc frozen by found. Latency is fixed at `NCHUNK+1`, for constant-time use.
- The result values are identical in both builds.

## Test plan
All scenarios use default parameters.
- `in_data=128'h0000_0000_0000_8000_0000_0000_0000_0000` -> `out_cnt=48`, `out_zero=0`. `out_valid` in cycle 3 with early exit, cycle 5 without.
- `in_data=0` -> `out_cnt=128`, `out_zero=1`, `out_valid` in cycle 5 in both builds.
- `in_data=128'h8000_..._0000` -> `out_cnt=0`. Cycle 2 with early exit, cycle 5 without. Also `in_data=1` -> `out_cnt=127`, cycle 5.
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid` -> `out_cnt`/`out_zero` stable, `in_ready=0`, `busy=1`. On release: handshake, then `in_ready=1` in the next cycle.
- Reset mid-operation: drive `rst_n=0` in cycle 2 of a scan -> all outputs are at reset values the next cycle and `out_valid` never asserts for that operand. A following operand 32'h1 in the low chunk gives `out_cnt=127`.
- Back-to-back: hold `in_valid=1` with operands A=0 and B=`128'h1<<100` -> B is accepted one cycle after A's result handshake. Results are 128 then 27, in order.
